// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - Guided operand/operator load sequencer for the board ALU.
// Two debounced buttons step through operand1, operand2, operator, execute and show.
module alu_sequencer #(
  parameter int NB_OP           = 6,
  parameter int NB_DATA         = 8,
  parameter int NB_OUT          = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               i_reset_n,
  input  logic [NB_DATA-1:0] switches,
  input  logic               btn_enter,
  input  logic               btn_back,
  input  logic [NB_OUT-1:0]  i_result,
  output logic [NB_DATA-1:0] o_operand1,
  output logic [NB_DATA-1:0] o_operand2,
  output logic [NB_OP-1:0]   o_operator,
  output logic               o_valid,
  output logic               o_error,
  output logic [2:0]         o_state,
  output logic [NB_OUT-1:0]  leds
);

  localparam int NB_CNT = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_OP1  = 3'd0,
    S_OP2  = 3'd1,
    S_OPR  = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  // Index 0 is the enter button, index 1 the back button.
  logic [1:0]        raw;
  logic [1:0]        sync1;
  logic [1:0]        sync2;
  logic [1:0]        deb;
  logic [1:0]        deb_d;
  logic [1:0]        pulse;
  logic [NB_CNT-1:0] cnt [2];

  logic enter_pulse;
  logic back_pulse;

  assign raw         = {btn_back, btn_enter};
  assign enter_pulse = pulse[0];
  assign back_pulse  = pulse[1];

  // The counter saturates one short of DEBOUNCE_CYCLES; the next differing cycle commits the level.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      pulse <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      pulse <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == NB_CNT'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  function automatic logic op_valid(input logic [NB_OP-1:0] op);
    case (op)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
      NB_OP'(6'b100110), NB_OP'(6'b100111), NB_OP'(6'b000011), NB_OP'(6'b000010):
        op_valid = 1'b1;
      default:
        op_valid = 1'b0;
    endcase
  endfunction

  state_t             state, state_n;
  logic [NB_DATA-1:0] op1_n, op2_n;
  logic [NB_OP-1:0]   opr_n;
  logic               err_n;
  logic [NB_OUT-1:0]  leds_n;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= S_OP1;
      o_operand1 <= '0;
      o_operand2 <= '0;
      o_operator <= '0;
      o_error    <= 1'b0;
      leds       <= '0;
    end else begin
      state      <= state_n;
      o_operand1 <= op1_n;
      o_operand2 <= op2_n;
      o_operator <= opr_n;
      o_error    <= err_n;
      leds       <= leds_n;
    end
  end

  // Enter is tested before back in every state, so a simultaneous back is dropped.
  always_comb begin
    state_n = state;
    op1_n   = o_operand1;
    op2_n   = o_operand2;
    opr_n   = o_operator;
    err_n   = o_error;
    leds_n  = leds;
    case (state)
      S_OP1: begin
        if (enter_pulse) begin
          op1_n   = switches;
          state_n = S_OP2;
        end
      end
      S_OP2: begin
        if (enter_pulse) begin
          op2_n   = switches;
          state_n = S_OPR;
        end else if (back_pulse) begin
          state_n = S_OP1;
        end
      end
      S_OPR: begin
        if (enter_pulse) begin
          if (op_valid(switches[NB_OP-1:0])) begin
            opr_n   = switches[NB_OP-1:0];
            err_n   = 1'b0;
            state_n = S_EXEC;
          end else begin
            err_n   = 1'b1;
          end
        end else if (back_pulse) begin
          state_n = S_OP2;
        end
      end
      S_EXEC: begin
        leds_n  = i_result;
        state_n = S_SHOW;
      end
      S_SHOW: begin
        if (enter_pulse) begin
          state_n = S_OP1;
        end else if (back_pulse) begin
          state_n = S_OPR;
        end
      end
      default: begin
        state_n = S_OP1;
      end
    endcase
  end

  assign o_valid = (state == S_EXEC);
  assign o_state = state;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - Directed self-checking bench for alu_sequencer.
// Walks the load sequence with hand-computed expected LED results.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [7:0]  switches = 8'h00;
  logic        btn_enter = 1'b0;
  logic        btn_back = 1'b0;
  logic [15:0] i_result;
  logic [7:0]  o_operand1;
  logic [7:0]  o_operand2;
  logic [5:0]  o_operator;
  logic        o_valid;
  logic        o_error;
  logic [2:0]  o_state;
  logic [15:0] leds;

  int checks = 0;
  int errors = 0;
  int valid_count = 0;
  int exec_count = 0;
  int vc0;
  int ec0;
  int lat;

  alu_sequencer #(
    .NB_OP(6), .NB_DATA(8), .NB_OUT(16), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .i_reset_n(i_reset_n), .switches(switches),
    .btn_enter(btn_enter), .btn_back(btn_back), .i_result(i_result),
    .o_operand1(o_operand1), .o_operand2(o_operand2), .o_operator(o_operator),
    .o_valid(o_valid), .o_error(o_error), .o_state(o_state), .leds(leds)
  );

  always #5 clk = ~clk;

  // Reference ALU for the operators exercised here.
  always_comb begin
    case (o_operator)
      6'b100000: i_result = {8'h00, o_operand1} + {8'h00, o_operand2};
      6'b100010: i_result = {8'h00, o_operand1} - {8'h00, o_operand2};
      6'b100100: i_result = {8'h00, o_operand1 & o_operand2};
      default:   i_result = 16'hDEAD;
    endcase
  end

  always @(posedge clk) begin
    if (o_valid === 1'b1) valid_count <= valid_count + 1;
    if (o_state === 3'd3) exec_count <= exec_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic e, input logic b);
    @(negedge clk);
    btn_enter = e;
    btn_back  = b;
    repeat (12) @(negedge clk);
    btn_enter = 1'b0;
    btn_back  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic enter(input logic [7:0] sw);
    switches = sw;
    press(1'b1, 1'b0);
  endtask

  initial begin
    #2;
    check("rst_state", o_state, 0);
    check("rst_op1", o_operand1, 0);
    check("rst_op2", o_operand2, 0);
    check("rst_opr", o_operator, 0);
    check("rst_valid", o_valid, 0);
    check("rst_error", o_error, 0);
    check("rst_leds", leds, 0);
    @(negedge clk);
    i_reset_n = 1'b1;

    press(1'b0, 1'b1);
    check("back_in_op1", o_state, 0);

    // First enter press also measures button-to-capture latency.
    switches = 8'h05;
    @(negedge clk);
    btn_enter = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (o_state !== 3'd0) begin
        lat = i;
        break;
      end
    end
    check("enter_latency", lat, 8);
    repeat (12) @(negedge clk);
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    check("add_op1", o_operand1, 8'h05);
    check("add_state1", o_state, 1);
    enter(8'h03);
    check("add_op2", o_operand2, 8'h03);
    check("add_state2", o_state, 2);
    vc0 = valid_count;
    ec0 = exec_count;
    enter(8'h20);
    check("add_state4", o_state, 4);
    check("add_opr", o_operator, 6'b100000);
    check("add_leds", leds, 16'h0008);
    check("add_valid_pulses", valid_count - vc0, 1);
    check("add_exec_cycles", exec_count - ec0, 1);

    enter(8'h00);
    check("show_to_op1", o_state, 0);
    check("leds_hold_op1", leds, 16'h0008);
    enter(8'h05);
    enter(8'h03);
    enter(8'h22);
    check("sub_leds", leds, 16'h0002);

    enter(8'h00);
    enter(8'h03);
    enter(8'h05);
    enter(8'h22);
    check("sub_neg_leds", leds, 16'hFFFE);

    enter(8'h00);
    check("op1_again", o_state, 0);
    @(negedge clk);
    btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    btn_enter = 1'b0;
    repeat (15) @(negedge clk);
    check("glitch_state", o_state, 0);
    check("glitch_op1", o_operand1, 8'h03);

    enter(8'h0C);
    enter(8'h0A);
    vc0 = valid_count;
    enter(8'h3F);
    check("bad_op_error", o_error, 1);
    check("bad_op_state", o_state, 2);
    check("bad_op_valid", valid_count - vc0, 0);
    check("bad_op_opr", o_operator, 6'b100010);
    enter(8'h24);
    check("and_error", o_error, 0);
    check("and_state", o_state, 4);
    check("and_leds", leds, 16'h0008);

    enter(8'h00);
    enter(8'h05);
    enter(8'h03);
    press(1'b0, 1'b1);
    check("back_opr_state", o_state, 1);
    check("back_keeps_op2", o_operand2, 8'h03);
    enter(8'h07);
    enter(8'h20);
    check("reload_leds", leds, 16'h000C);
    check("reload_op1", o_operand1, 8'h05);
    press(1'b0, 1'b1);
    check("back_show_state", o_state, 2);
    check("back_show_leds", leds, 16'h000C);
    press(1'b0, 1'b1);
    check("back_to_op2", o_state, 1);
    switches = 8'h09;
    press(1'b1, 1'b1);
    check("both_state", o_state, 2);
    check("both_op2", o_operand2, 8'h09);

    press(1'b0, 1'b1);
    enter(8'h03);
    check("pre_rst_state", o_state, 2);
    check("pre_rst_op2", o_operand2, 8'h03);
    @(posedge clk);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("mid_rst_state", o_state, 0);
    check("mid_rst_op1", o_operand1, 0);
    check("mid_rst_op2", o_operand2, 0);
    check("mid_rst_opr", o_operator, 0);
    check("mid_rst_leds", leds, 0);
    check("mid_rst_valid", o_valid, 0);
    @(negedge clk);
    i_reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_state", o_state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
